shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl_pkg.sv | 25 ++
 rtl/shift_seq_ctrl_if.sv | 25 ++
 rtl/shift_seq_ctrl_shift_step.sv | 21 ++
 rtl/shift_seq_ctrl.sv | 97 +++++++++
 tb/tb_shift_seq_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the sequential shifter: op codes, FSM states and widths.
// Reused by the control unit, the one-bit step and the interface.
package shift_seq_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic op_is_legal(input op_e op);
        return op != OP_RSV;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle of the sequential shifter. A request is accepted on a rising
// edge where start=1 and busy=0; the result C is valid in the single cycle done=1.
interface shift_seq_ctrl_if;
    import shift_seq_ctrl_pkg::*;

    logic                 start;
    logic [1:0]           op;
    logic [DATA_W-1:0]    A;
    logic [SHAMT_W-1:0]   shamt;
    logic                 busy;
    logic                 done;
    logic [DATA_W-1:0]    C;
    logic                 err;

    modport master (
        output start, op, A, shamt,
        input  busy, done, C, err
    );

    modport slave (
        input  start, op, A, shamt,
        output busy, done, C, err
    );

endinterface

// File: rtl/shift_seq_ctrl_shift_step.sv
// One-bit shift step: purely combinational next value of the result register.
// SRA replicates the current bit 31, which always equals the captured sign bit.
module shift_step
    import shift_seq_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] i_c,
    input  op_e               i_op,
    output logic [DATA_W-1:0] o_c
);

    always_comb begin
        o_c = i_c;
        case (i_op)
            OP_SLL:  o_c = {i_c[DATA_W-2:0], 1'b0};
            OP_SRL:  o_c = {1'b0, i_c[DATA_W-1:1]};
            OP_SRA:  o_c = {i_c[DATA_W-1], i_c[DATA_W-1:1]};
            default: o_c = i_c;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shift controller: one bit per cycle, result ready shamt+1 cycles after
// the accepting edge. Reserved ops load A and report err instead of done.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    shift_seq_ctrl_if.slave    bus,
    output state_e             o_dbg_state,
    output logic [SHAMT_W-1:0] o_dbg_count
);

    state_e             r_state;
    logic [DATA_W-1:0]  r_c;
    logic [SHAMT_W-1:0] r_count;
    op_e                r_op;
    logic               r_err;

    state_e             w_state_nxt;
    logic [DATA_W-1:0]  w_c_nxt;
    logic [SHAMT_W-1:0] w_count_nxt;
    op_e                w_op_nxt;
    logic               w_err_nxt;
    logic [DATA_W-1:0]  w_step_c;
    logic               w_accept;
    op_e                w_op_in;

    assign w_op_in  = op_e'(bus.op);
    assign w_accept = bus.start && (r_state != ST_SHIFT);

    shift_step u_step (
        .i_c  (r_c),
        .i_op (r_op),
        .o_c  (w_step_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_count <= '0;
            r_op    <= OP_SLL;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_SHIFT: begin
                w_c_nxt = w_step_c;
                // count stops at zero; the last step hands over to DONE
                if (r_count <= SHAMT_W'(1)) begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_count_nxt = r_count - SHAMT_W'(1);
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (w_accept) begin
            w_c_nxt     = bus.A;
            w_count_nxt = bus.shamt;
            w_op_nxt    = w_op_in;
            if (!op_is_legal(w_op_in)) begin
                w_state_nxt = ST_IDLE;
                w_err_nxt   = 1'b1;
            end else if (bus.shamt == '0) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_state_nxt = ST_SHIFT;
            end
        end
    end

    assign bus.busy    = (r_state == ST_SHIFT);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.C       = r_c;
    assign bus.err     = r_err;
    assign o_dbg_state = r_state;
    assign o_dbg_count = r_count;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed cases plus randomized operations checked
// against an arithmetic reference (<<, >>, >>>) and a shamt+1 latency rule.
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    state_e     dbg_state;
    logic [4:0] dbg_count;

    shift_seq_ctrl_if bus();

    shift_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_count (dbg_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input int s);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return sa >>> s;
            default: return a;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done/err cycle with start low.
    // inject: 0 none, 1 random starts during the shift, 2 one start (A=1,shamt=1) at cycle 3.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s,
                          input int inject);
        int   lat;
        logic legal;
        legal = (op != 2'b11);
        lat   = legal ? int'(s) + 1 : 1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.shamt = s;
        exp_q.push_back(ref_shift(op, a, int'(s)));
        @(posedge clk);
        @(negedge clk);
        for (int cyc = 1; cyc <= lat; cyc++) begin
            check("done_err_excl", {31'b0, bus.done & bus.err}, 32'd0);
            if (cyc < lat) begin
                check("busy_during", {31'b0, bus.busy}, 32'd1);
                check("done_early", {31'b0, bus.done}, 32'd0);
                case (inject)
                    1: begin
                        bus.start = 1'($urandom_range(0, 1));
                        bus.op    = 2'($urandom);
                        bus.A     = $urandom;
                        bus.shamt = 5'($urandom);
                    end
                    2: begin
                        bus.start = (cyc == 3);
                        bus.op    = 2'b00;
                        bus.A     = 32'h1;
                        bus.shamt = 5'd1;
                    end
                    default: bus.start = 1'b0;
                endcase
                @(negedge clk);
            end else begin
                last_exp = exp_q.pop_front();
                check("busy_end", {31'b0, bus.busy}, 32'd0);
                check("done", {31'b0, bus.done}, {31'b0, legal});
                check("err", {31'b0, bus.err}, {31'b0, ~legal});
                check("result", bus.C, last_exp);
                if (!legal) check("rsv_state", 32'(dbg_state), 32'(ST_IDLE));
                bus.start = 1'b0;
            end
        end
    endtask

    // One quiet cycle after a result: no pulses, C held, back in IDLE.
    task automatic idle_after();
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_done", {31'b0, bus.done}, 32'd0);
        check("idle_err", {31'b0, bus.err}, 32'd0);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        check("idle_hold", bus.C, last_exp);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [4:0]  r_s;

        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = 32'hDEAD_BEEF;
        bus.shamt = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_c", bus.C, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_count", {27'b0, dbg_count}, 32'd0);
        rst = 1'b0;

        // first start right after reset release
        run_op(2'b00, 32'h0000_0001, 5'd31, 0);
        idle_after();
        run_op(2'b10, 32'h8000_0000, 5'd4, 0);
        // accepted straight from DONE
        run_op(2'b01, 32'h8000_0000, 5'd4, 0);
        idle_after();
        run_op(2'b01, 32'h1234_5678, 5'd0, 0);
        idle_after();
        run_op(2'b00, 32'h0000_000F, 5'd8, 2);
        idle_after();
        run_op(2'b11, 32'hAAAA_5555, 5'($urandom), 0);
        idle_after();

        // reset in the middle of a long shift
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = $urandom;
        bus.shamt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_c", bus.C, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        run_op(2'b01, 32'hC0FF_EE00, 5'd7, 0);
        idle_after();

        // randomized operations, some back-to-back from DONE
        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_s  = 5'($urandom_range(0, 31));
            run_op(r_op, r_a, r_s, 1);
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
